// File: rtl/accum_rr_sched_pkg.sv
// Shared constants for the round-robin accumulator scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package accum_rr_sched_pkg;

  // Number of requesters sharing the accumulator
  localparam int REQ_N = 2;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/accum_rr_sched_add_core.sv
// N-bit adder with unsigned carry-out and signed two's-complement overflow detect.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module accum_add_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  logic [N:0] full;

  // Widen by one bit so the carry-out falls out of the add directly
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    sum   = full[N-1:0];
    carry = full[N];
    // Overflow: operands share a sign and the result sign differs from it
    ovf   = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
  end

endmodule

// File: rtl/accum_rr_sched.sv
// Round-robin scheduler granting one shared accumulator to one of two requesters per burst.
// Latency: grant 1 cycle after request; res_valid on the 2nd rising edge after the last beat.
// Backpressure: beats are only taken from the granted requester when its dvalid is high; others are ignored.
module accum_rr_sched
  import accum_rr_sched_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BEATS = 16,
  parameter int CW        = 5
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [REQ_N-1:0] req,
  input  logic [N-1:0]     din0,
  input  logic [N-1:0]     din1,
  input  logic [REQ_N-1:0] dvalid,
  input  logic [REQ_N-1:0] dlast,
  output logic [REQ_N-1:0] gnt,
  output logic [N-1:0]     res,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             res_id,
  output logic             res_valid,
  output logic             busy
);

  state_t         state;
  logic [N-1:0]   acc;
  logic           carry_q;
  logic           ovf_q;
  logic [CW-1:0]  cnt;
  logic           ptr;
  logic           gid;

  logic [N-1:0]   din_g;
  logic           dv_g;
  logic           dl_g;
  logic           rq_g;
  logic           last_beat;
  logic           sel;
  logic [N-1:0]   add_sum;
  logic           add_c;
  logic           add_v;

  // Steer the granted requester's signals and pick the next winner
  always_comb begin
    din_g     = gid ? din1 : din0;
    dv_g      = dvalid[gid];
    dl_g      = dlast[gid];
    rq_g      = req[gid];
    // The beat that fills the burst to MAX_BEATS closes it even without dlast
    last_beat = dl_g || (cnt == CW'(MAX_BEATS - 1));
    // Pointed requester wins if it asks, otherwise the other one
    sel       = req[ptr] ? ptr : ~ptr;
  end

  accum_add_core #(.N(N)) u_add (
    .a     (acc),
    .b     (din_g),
    .sum   (add_sum),
    .carry (add_c),
    .ovf   (add_v)
  );

  assign busy = (state != ST_IDLE);

  // Scheduler FSM with accumulator, sticky flags, beat counter and result registers
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= ST_IDLE;
      acc       <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt       <= '0;
      ptr       <= 1'b0;
      gid       <= 1'b0;
      gnt       <= '0;
      res       <= '0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            gid     <= sel;
            gnt     <= {sel, ~sel};
            acc     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
            state   <= ST_ACC;
          end
        end
        ST_ACC: begin
          // A dropped request wins over any beat presented in the same cycle
          if (!rq_g) begin
            gnt   <= '0;
            ptr   <= ~gid;
            state <= ST_IDLE;
          end else if (dv_g) begin
            acc     <= add_sum;
            carry_q <= carry_q | add_c;
            ovf_q   <= ovf_q | add_v;
            cnt     <= cnt + CW'(1);
            if (last_beat) begin
              gnt   <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          res_valid <= 1'b1;
          res       <= acc;
          res_carry <= carry_q;
          res_ovf   <= ovf_q;
          res_id    <= gid;
          ptr       <= ~gid;
          state     <= ST_IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_rr_sched.sv
// Self-checking bench for accum_rr_sched with a sum/flag reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_accum_rr_sched;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] dvalid = 2'b00;
  logic [1:0] dlast = 2'b00;
  logic [7:0] din0 = 8'd0;
  logic [7:0] din1 = 8'd0;
  logic [1:0] gnt;
  logic [7:0] res;
  logic       res_carry;
  logic       res_ovf;
  logic       res_id;
  logic       res_valid;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  int ops[$];
  bit m_ptr = 1'b0;
  int exp_sum;
  bit exp_c;
  bit exp_v;
  int last_res = 0;

  accum_rr_sched #(.N(8), .MAX_BEATS(16), .CW(5)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .dvalid    (dvalid),
    .dlast     (dlast),
    .gnt       (gnt),
    .res       (res),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic over the burst operands
  function automatic void model_burst();
    int u = 0;
    bit c = 1'b0;
    bit v = 1'b0;
    foreach (ops[i]) begin
      int so = (ops[i] > 127) ? ops[i] - 256 : ops[i];
      int sa = (u > 127) ? u - 256 : u;
      if (sa + so > 127 || sa + so < -128) v = 1'b1;
      u = u + ops[i];
      if (u > 255) begin
        c = 1'b1;
        u = u - 256;
      end
    end
    exp_sum = u;
    exp_c   = c;
    exp_v   = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [1:0] g, output bit to);
    to = 1'b1;
    g  = 2'b00;
    for (int i = 0; i < 8 && to; i++) begin
      tick();
      if (gnt !== 2'b00) begin
        g  = gnt;
        to = 1'b0;
      end
    end
  endtask

  // Noise on the non-granted side, which the scheduler must ignore
  task automatic stray(input int id);
    int other = 1 - id;
    dvalid[other] = 1'($urandom_range(1, 0));
    dlast[other]  = 1'($urandom_range(1, 0));
    if (other == 0) din0 = 8'($urandom);
    else            din1 = 8'($urandom);
  endtask

  task automatic send_beats(input int id, input bit use_last, input int gapmax);
    foreach (ops[i]) begin
      int gaps = $urandom_range(gapmax, 0);
      repeat (gaps) begin
        dvalid[id] = 1'b0;
        dlast[id]  = 1'b0;
        if (id == 0) din0 = 8'($urandom);
        else         din1 = 8'($urandom);
        stray(id);
        tick();
      end
      dvalid[id] = 1'b1;
      dlast[id]  = use_last && (i == ops.size() - 1);
      if (id == 0) din0 = 8'(ops[i]);
      else         din1 = 8'(ops[i]);
      stray(id);
      tick();
    end
    dvalid = 2'b00;
    dlast  = 2'b00;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    #2;
    n_chk++;
    if ({gnt, res_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got gnt=%b vld=%b busy=%b required 00 0 0", gnt, res_valid, busy);
    end
    n_chk++;
    if ({res, res_carry, res_ovf, res_id} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_res: got res=%0d c=%b v=%b id=%b required all 0", res, res_carry, res_ovf, res_id);
    end
    @(negedge clk);
    aclr = 1'b0;
    tick();
    n_chk++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got gnt=%b busy=%b required 00 0", gnt, busy);
    end
    m_ptr = 1'b0;
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    bit to;
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      int e = m_ptr;
      wait_gnt(g, to);
      n_chk++;
      if (to || g !== 2'(1 << e)) begin
        n_fail++;
        $display("FAIL alt_gnt[%0d]: got %b (timeout=%0d) required %b", k, g, to, 2'(1 << e));
      end
      dvalid[e] = 1'b1;
      dlast[e]  = 1'b1;
      if (e == 0) din0 = 8'(k + 1);
      else        din1 = 8'(k + 1);
      stray(e);
      tick();
      dvalid = 2'b00;
      dlast  = 2'b00;
      tick();
      n_chk++;
      if (res_valid !== 1'b1 || res_id !== 1'(e) || res !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL alt_res[%0d]: got vld=%b id=%b res=%0d required 1 %0d %0d", k, res_valid, res_id, res, e, k + 1);
      end
      m_ptr = ~1'(e);
    end
    req = 2'b00;
    last_res = 6;
    tick();
  endtask

  task automatic test_single_bursts();
    logic [1:0] g;
    bit to;
    for (int k = 0; k < 15; k++) begin
      int id;
      ops.delete();
      case (k)
        0: begin id = 0; ops.push_back(10);  ops.push_back(20); ops.push_back(30); end
        1: begin id = 1; ops.push_back(200); ops.push_back(100); end
        2: begin id = 0; ops.push_back(100); ops.push_back(50); end
        default: begin
          id = $urandom_range(1, 0);
          repeat ($urandom_range(6, 1)) ops.push_back($urandom_range(255, 0));
        end
      endcase
      model_burst();
      req[id] = 1'b1;
      n_chk++;
      if (gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL same_cycle_gnt[%0d]: got %b required 00", k, gnt);
      end
      wait_gnt(g, to);
      n_chk++;
      if (to || g !== 2'(1 << id) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_gnt[%0d]: got %b busy=%b (timeout=%0d) required %b busy=1", k, g, busy, to, 2'(1 << id));
      end
      send_beats(id, 1'b1, 2);
      req[id] = 1'b0;
      n_chk++;
      if (gnt !== 2'b00 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_done[%0d]: got gnt=%b vld=%b required 00 0", k, gnt, res_valid);
      end
      tick();
      n_chk++;
      if (res_valid !== 1'b1 || res !== 8'(exp_sum) || res_carry !== exp_c || res_ovf !== exp_v || res_id !== 1'(id)) begin
        n_fail++;
        $display("FAIL burst_res[%0d]: got vld=%b res=%0d c=%b v=%b id=%b required 1 %0d %b %b %0d",
                 k, res_valid, res, res_carry, res_ovf, res_id, exp_sum, exp_c, exp_v, id);
      end
      tick();
      n_chk++;
      if (res_valid !== 1'b0 || res !== 8'(exp_sum) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_hold[%0d]: got vld=%b res=%0d busy=%b required 0 %0d 0", k, res_valid, res, busy, exp_sum);
      end
      m_ptr = ~1'(id);
      last_res = exp_sum;
    end
  endtask

  task automatic test_forced_last();
    logic [1:0] g;
    bit to;
    ops.delete();
    repeat (16) ops.push_back(1);
    req = 2'b01;
    wait_gnt(g, to);
    n_chk++;
    if (to || g !== 2'b01) begin
      n_fail++;
      $display("FAIL forced_gnt: got %b (timeout=%0d) required 01", g, to);
    end
    send_beats(0, 1'b0, 1);
    n_chk++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL forced_last: got gnt=%b after 16th beat required 00", gnt);
    end
    req = 2'b00;
    tick();
    n_chk++;
    if (res_valid !== 1'b1 || res !== 8'd16 || res_carry !== 1'b0 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_res: got vld=%b res=%0d c=%b v=%b required 1 16 0 0", res_valid, res, res_carry, res_ovf);
    end
    tick();
    m_ptr = 1'b1;
    last_res = 16;
  endtask

  task automatic test_abort();
    logic [1:0] g;
    bit to;
    ops.delete();
    ops.push_back(7);
    ops.push_back(9);
    req = 2'b01;
    wait_gnt(g, to);
    n_chk++;
    if (to || g !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_gnt: got %b (timeout=%0d) required 01", g, to);
    end
    send_beats(0, 1'b0, 1);
    // Drop req0 with a beat presented in the same cycle
    req = 2'b10;
    dvalid[0] = 1'b1;
    dlast[0] = 1'b1;
    din0 = 8'd99;
    tick();
    dvalid = 2'b00;
    dlast = 2'b00;
    n_chk++;
    if (gnt !== 2'b00 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got gnt=%b busy=%b vld=%b required 00 0 0", gnt, busy, res_valid);
    end
    m_ptr = 1'b1;
    req = 2'b11;
    tick();
    n_chk++;
    if (gnt !== 2'b10 || res_valid !== 1'b0 || res !== 8'(last_res)) begin
      n_fail++;
      $display("FAIL abort_next: got gnt=%b vld=%b res=%0d required 10 0 %0d", gnt, res_valid, res, last_res);
    end
    req = 2'b10;
    ops.delete();
    ops.push_back(5);
    ops.push_back(6);
    send_beats(1, 1'b1, 1);
    req = 2'b00;
    tick();
    n_chk++;
    if (res_valid !== 1'b1 || res !== 8'd11 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_after_res: got vld=%b res=%0d id=%b required 1 11 1", res_valid, res, res_id);
    end
    m_ptr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    bit to;
    ops.delete();
    ops.push_back(50);
    ops.push_back(60);
    req = 2'b01;
    wait_gnt(g, to);
    send_beats(0, 1'b0, 0);
    #2;
    aclr = 1'b1;
    #1;
    n_chk++;
    if ({gnt, res_valid, busy, res, res_carry, res_ovf, res_id} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got gnt=%b vld=%b busy=%b res=%0d c=%b v=%b id=%b required all 0",
               gnt, res_valid, busy, res, res_carry, res_ovf, res_id);
    end
    #2;
    aclr = 1'b0;
    m_ptr = 1'b0;
    ops.delete();
    ops.push_back(40);
    ops.push_back(2);
    ops.push_back(3);
    ops.push_back(130);
    model_burst();
    wait_gnt(g, to);
    n_chk++;
    if (to || g !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_regnt: got %b (timeout=%0d) required 01", g, to);
    end
    send_beats(0, 1'b1, 1);
    req = 2'b00;
    tick();
    n_chk++;
    if (res_valid !== 1'b1 || res !== 8'(exp_sum) || res_carry !== exp_c || res_ovf !== exp_v) begin
      n_fail++;
      $display("FAIL reset_resum: got vld=%b res=%0d c=%b v=%b required 1 %0d %b %b",
               res_valid, res, res_carry, res_ovf, exp_sum, exp_c, exp_v);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_bursts();
    test_forced_last();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
